// File: rtl/linked_list_sum_pkg.sv
// Shared types and node-layout constants for the linked-list summing unit.
// A node is two consecutive words: value at p, next pointer at p+1.
package linked_list_sum_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_VAL  = 2'd1,
        FETCH_NEXT = 2'd2,
        DONE       = 2'd3
    } llsum_state_e;

    localparam int NODE_VAL_OFS  = 0;
    localparam int NODE_NEXT_OFS = 1;
    localparam int NULL_PTR      = 0;

endpackage

// File: rtl/linked_list_sum_unit_memory.sv
// Node store for the summing unit: synchronous write, asynchronous read.
module list_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/linked_list_sum_unit.sv
// Walks a singly linked list in list_memory and accumulates node values.
// Optional loop guard: define LLSUM_LOOP_GUARD_EN to abort after MAX_NODES nodes.
//
// state      | meaning
// IDLE       | waiting for start; host may write memory
// FETCH_VAL  | add mem[ptr] into the accumulator
// FETCH_NEXT | load ptr from mem[ptr+1]; zero ends the list
// DONE       | one-cycle done pulse, result held on sum_o
module linked_list_sum_unit
    import linked_list_sum_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int SUM_WIDTH  = DATA_WIDTH,
    parameter int MAX_NODES  = 16
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] head_ptr,
    output logic                  busy,
    output logic                  done,
    output logic [SUM_WIDTH-1:0]  sum_o,
    output logic                  overflow,
    output logic                  error
);

    llsum_state_e          state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] next_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [SUM_WIDTH:0]    sum_ext;
    logic                  mem_wr_en;

    // Host writes are locked out during traversal so the list cannot change underneath us.
    assign mem_wr_en = wr_en & ~busy;

    assign rd_addr  = (state == FETCH_NEXT) ? ptr + ADDR_WIDTH'(NODE_NEXT_OFS)
                                            : ptr + ADDR_WIDTH'(NODE_VAL_OFS);
    assign next_ptr = rd_data[ADDR_WIDTH-1:0];
    assign sum_ext  = {1'b0, sum_o} + (SUM_WIDTH+1)'(rd_data);

    list_memory #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_list_memory (
        .Clk    (Clk),
        .wr_en  (mem_wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

`ifdef LLSUM_LOOP_GUARD_EN
    localparam int CNT_W = $clog2(MAX_NODES + 1);
    logic [CNT_W-1:0] node_cnt;
`else
    // MAX_NODES only matters with the guard built in; error is constant 0 here.
    assign error = (MAX_NODES < 0);
`endif

    always_ff @(posedge Clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            sum_o    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
`ifdef LLSUM_LOOP_GUARD_EN
            error    <= 1'b0;
            node_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sum_o    <= '0;
                        overflow <= 1'b0;
`ifdef LLSUM_LOOP_GUARD_EN
                        error    <= 1'b0;
                        node_cnt <= '0;
`endif
                        if (head_ptr != ADDR_WIDTH'(NULL_PTR)) begin
                            ptr   <= head_ptr;
                            busy  <= 1'b1;
                            state <= FETCH_VAL;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH_VAL: begin
                    sum_o <= sum_ext[SUM_WIDTH-1:0];
                    if (sum_ext[SUM_WIDTH]) begin
                        overflow <= 1'b1;
                    end
`ifdef LLSUM_LOOP_GUARD_EN
                    node_cnt <= node_cnt + 1'b1;
`endif
                    state <= FETCH_NEXT;
                end
                FETCH_NEXT: begin
                    ptr <= next_ptr;
                    if (next_ptr == ADDR_WIDTH'(NULL_PTR)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`ifdef LLSUM_LOOP_GUARD_EN
                    else if (node_cnt == CNT_W'(MAX_NODES)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`endif
                    else begin
                        state <= FETCH_VAL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linked_list_sum_unit.sv
// Randomised and directed bench for linked_list_sum_unit against a list-walking reference model.
module tb_linked_list_sum_unit;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int SW   = 8;
    localparam int MAXN = 16;
`ifdef LLSUM_LOOP_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [AW-1:0] head_ptr;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum_o;
    logic          overflow;
    logic          error;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    linked_list_sum_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .SUM_WIDTH (SW),
        .MAX_NODES (MAXN)
    ) dut (
        .Clk     (Clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .head_ptr(head_ptr),
        .busy    (busy),
        .done    (done),
        .sum_o   (sum_o),
        .overflow(overflow),
        .error   (error)
    );

    // Reference model: shadow memory plus "busy cycles left" and a done flag.
    int m_mem [256];
    bit m_valid     = 1'b0;
    int m_busy_left = 0;
    bit m_done      = 1'b0;
    int m_sum       = 0;
    bit m_ovf       = 1'b0;
    bit m_err       = 1'b0;
    int p_sum       = 0;
    bit p_ovf       = 1'b0;
    bit p_err       = 1'b0;

    function automatic void traverse(input int head, output int n, output int s,
                                     output bit ovf, output bit err);
        int p     = head;
        int total = 0;
        int nxt;
        n   = 0;
        err = 1'b0;
        while (1) begin
            total += m_mem[p];
            n++;
            nxt = m_mem[(p + 1) % 256];
            if (nxt == 0) break;
            if (GUARD && n == MAXN) begin
                err = 1'b1;
                break;
            end
            if (n >= 1000) begin
                n = -1;
                break;
            end
            p = nxt;
        end
        s   = total % 256;
        ovf = (total > 255);
    endfunction

    always @(posedge Clk) begin
        int n, s;
        bit o, e;
        if (wr_en === 1'b1 && m_busy_left == 0) m_mem[wr_addr] = int'(wr_data);
        if (reset === 1'b1) begin
            m_valid     = 1'b1;
            m_busy_left = 0;
            m_done      = 1'b0;
            m_sum       = 0;
            m_ovf       = 1'b0;
            m_err       = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_done = 1'b1;
                m_sum  = p_sum;
                m_ovf  = p_ovf;
                m_err  = p_err;
            end
        end else if (start === 1'b1) begin
            if (head_ptr == 0) begin
                m_done = 1'b1;
                m_sum  = 0;
                m_ovf  = 1'b0;
                m_err  = 1'b0;
            end else begin
                traverse(int'(head_ptr), n, s, o, e);
                p_sum       = s;
                p_ovf       = o;
                p_err       = e;
                m_busy_left = (n < 0) ? (1 << 30) : 2 * n;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (!m_valid) return;
        check("busy", 32'(busy), 32'(m_busy_left > 0));
        check("done", 32'(done), 32'(m_done));
        if (m_busy_left == 0) begin
            check("sum_o",    32'(sum_o),    32'(m_sum));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("error",    32'(error),    32'(m_err));
        end
    endtask

    // One cycle: compare mid-cycle, then land just after the next rising edge.
    task automatic step();
        @(negedge Clk);
        compare();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_mem(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Start at cycle 0, return in the done cycle with its cycle number and busy count.
    task automatic run(input int head, input int limit, input bit jitter,
                       output int done_cyc, output int busy_cnt);
        int cyc;
        start    = 1'b1;
        head_ptr = AW'(head);
        step();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < limit) begin
            if (busy === 1'b1) busy_cnt++;
            if (jitter) begin
                start    = ($urandom_range(3) == 0);
                head_ptr = AW'($urandom_range(255));
                wr_en    = ($urandom_range(3) == 0);
                wr_addr  = AW'($urandom_range(255));
                wr_data  = DW'($urandom_range(255));
            end
            step();
            cyc++;
        end
        start    = 1'b0;
        wr_en    = 1'b0;
        done_cyc = (done === 1'b1) ? cyc : -1;
        check("run_done_seen", 32'(done), 32'd1);
    endtask

    task automatic load_three_node();
        write_mem(2, 5);
        write_mem(3, 6);
        write_mem(6, 7);
        write_mem(7, 10);
        write_mem(10, 9);
        write_mem(11, 0);
    endtask

    initial begin
        int dc, bc, cyc;
        int nn;
        int addrs [6];
        bit used [256];

        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        head_ptr = '0;
        repeat (3) step();
        reset = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum_o), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_err",  32'(error), 32'd0);

        for (int a = 0; a < 256; a++) write_mem(a, 0);

        // Three-node list
        load_three_node();
        step();
        run(2, 100, 1'b0, dc, bc);
        check("3n_done_cycle", 32'(dc), 32'd7);
        check("3n_sum", 32'(sum_o), 32'd21);
        check("3n_ovf", 32'(overflow), 32'd0);
        check("3n_busy_cycles", 32'(bc), 32'd6);
        check("3n_model_sum", 32'(m_sum), 32'd21);
        step();
        step();
        check("3n_sum_held", 32'(sum_o), 32'd21);

        // Empty list
        run(0, 100, 1'b0, dc, bc);
        check("empty_done_cycle", 32'(dc), 32'd1);
        check("empty_sum", 32'(sum_o), 32'd0);
        check("empty_busy_cycles", 32'(bc), 32'd0);
        step();

        // Accumulator overflow
        write_mem(2, 200);
        write_mem(3, 4);
        write_mem(4, 100);
        write_mem(5, 0);
        run(2, 100, 1'b0, dc, bc);
        check("ovf_done_cycle", 32'(dc), 32'd5);
        check("ovf_sum", 32'(sum_o), 32'd44);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_model_flag", 32'(m_ovf), 32'd1);
        step();

        // Node at the top address: next pointer wraps to address 0
        write_mem(255, 3);
        write_mem(0, 0);
        run(255, 100, 1'b0, dc, bc);
        check("wrap_done_cycle", 32'(dc), 32'd3);
        check("wrap_sum", 32'(sum_o), 32'd3);
        step();

        // Reset in cycle 3 of the three-node walk
        load_three_node();
        start    = 1'b1;
        head_ptr = AW'(2);
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_sum", 32'(sum_o), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        step();
        run(2, 100, 1'b0, dc, bc);
        check("midrst_restart_sum", 32'(sum_o), 32'd21);
        step();

        // Busy interlock: write in cycle 2 and start in cycle 4 are both ignored
        start    = 1'b1;
        head_ptr = AW'(2);
        step();
        start = 1'b0;
        step();
        wr_en   = 1'b1;
        wr_addr = AW'(6);
        wr_data = DW'(99);
        step();
        wr_en = 1'b0;
        step();
        start    = 1'b1;
        head_ptr = AW'(10);
        step();
        start = 1'b0;
        cyc   = 5;
        while (done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("lock_done_cycle", 32'(cyc), 32'd7);
        check("lock_sum", 32'(sum_o), 32'd21);
        check("lock_model_mem6", 32'(m_mem[6]), 32'd7);
        step();

        // Self-referencing node
        write_mem(4, 1);
        write_mem(5, 4);
`ifdef LLSUM_LOOP_GUARD_EN
        run(4, 250, 1'b0, dc, bc);
        check("guard_done_cycle", 32'(dc), 32'd33);
        check("guard_err", 32'(error), 32'd1);
        check("guard_sum", 32'(sum_o), 32'd16);
        check("guard_model_err", 32'(m_err), 32'd1);
        step();
`else
        start    = 1'b1;
        head_ptr = AW'(4);
        step();
        start = 1'b0;
        repeat (199) step();
        check("noguard_busy_c200", 32'(busy), 32'd1);
        check("noguard_err", 32'(error), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        // Random lists with random start/write noise while busy
        for (int t = 0; t < 15; t++) begin
            nn = int'($urandom_range(1, 6));
            for (int a = 0; a < 256; a++) used[a] = 1'b0;
            for (int k = 0; k < nn; k++) begin
                do addrs[k] = 2 * int'($urandom_range(1, 127));
                while (used[addrs[k]]);
                used[addrs[k]] = 1'b1;
            end
            for (int k = 0; k < nn; k++) begin
                write_mem(addrs[k], int'($urandom_range(255)));
                write_mem(addrs[k] + 1, (k == nn - 1) ? 0 : addrs[k + 1]);
            end
            run(addrs[0], 60, 1'b1, dc, bc);
            check("rand_done_cycle", 32'(dc), 32'(2 * nn + 1));
            step();
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
